// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared state encoding and sizing helper for the capture framer
package capture_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } capture_state_t;

   // A one-lane framer still needs a 1-bit index so the lane register stays addressable.
   function automatic int lane_idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/capture_framer.sv
// rtl/capture_framer.sv - packs accepted samples into IN_NUM-lane frames and closes the sink once
module capture_framer
   import capture_pkg::*;
#(
   parameter int IN_WIDTH = 8,
   parameter int IN_NUM   = 4,
   parameter int FRAME_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       arm,
   input  logic                       stop,
   input  logic [FRAME_W-1:0]         numFrames,
   input  logic                       inValid,
   output logic                       inReady,
   input  logic signed [IN_WIDTH-1:0] dataIn,
   output logic                       en,
   output logic signed [IN_WIDTH-1:0] dataOut [IN_NUM],
   output logic                       closed,
   output logic                       busy,
   output logic [FRAME_W-1:0]         frameCnt
);

   localparam int LANE_W = lane_idx_width(IN_NUM);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(IN_NUM - 1);

   capture_state_t              state;
   logic [LANE_W-1:0]           laneIdx;
   logic signed [IN_WIDTH-1:0]  lanes [IN_NUM];
   logic [FRAME_W-1:0]          frameLimit;
   logic                        accept;
   logic                        frame_done;
   logic [FRAME_W-1:0]          cnt_next;

   assign inReady    = (state != FLUSH);
   assign busy       = (state == CAPTURE) || (state == FLUSH);
   assign accept     = inValid && inReady;
   assign frame_done = (state == CAPTURE) && accept && (laneIdx == LAST_LANE);
   // Saturating count; in limited mode the limit is always reached before saturation.
   assign cnt_next   = (&frameCnt) ? frameCnt : frameCnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         laneIdx    <= '0;
         frameLimit <= '0;
         frameCnt   <= '0;
         en         <= 1'b0;
         closed     <= 1'b0;
         for (int i = 0; i < IN_NUM; i++) begin
            lanes[i]   <= '0;
            dataOut[i] <= '0;
         end
      end else begin
         en <= 1'b0;
         case (state)
            IDLE: begin
               if (arm) begin
                  state      <= CAPTURE;
                  frameLimit <= numFrames;
                  frameCnt   <= '0;
                  laneIdx    <= '0;
               end
            end
            CAPTURE: begin
               if (frame_done) begin
                  for (int i = 0; i < IN_NUM; i++)
                     dataOut[i] <= (i == IN_NUM - 1) ? dataIn : lanes[i];
                  en       <= 1'b1;
                  frameCnt <= cnt_next;
                  laneIdx  <= '0;
                  if (stop || ((frameLimit != '0) && (cnt_next == frameLimit)))
                     state <= DONE;
               end else begin
                  if (accept) begin
                     lanes[laneIdx] <= dataIn;
                     laneIdx        <= laneIdx + 1'b1;
                  end
                  // A sample accepted alongside stop joins the padded frame.
                  if (stop)
                     state <= (accept || (laneIdx != '0)) ? FLUSH : DONE;
               end
            end
            FLUSH: begin
               for (int i = 0; i < IN_NUM; i++)
                  dataOut[i] <= (i < int'(laneIdx)) ? lanes[i] : '0;
               en       <= 1'b1;
               frameCnt <= cnt_next;
               laneIdx  <= '0;
               state    <= DONE;
            end
            DONE: begin
               closed <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_capture_framer.sv
// tb/tb_capture_framer.sv - directed bench for capture_framer
module tb_capture_framer;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              arm = 1'b0;
   logic              stop = 1'b0;
   logic [15:0]       numFrames = '0;
   logic              inValid = 1'b0;
   logic              inReady;
   logic signed [7:0] dataIn = '0;
   logic              en;
   logic signed [7:0] dataOut [4];
   logic              closed;
   logic              busy;
   logic [15:0]       frameCnt;

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int start = 0;
   int close_cyc = -1;
   int nr_cnt = 0;
   logic [31:0] frames_q[$];
   int en_q[$];

   capture_framer #(.IN_WIDTH(8), .IN_NUM(4), .FRAME_W(16)) dut (
      .clk(clk), .rst(rst), .arm(arm), .stop(stop), .numFrames(numFrames),
      .inValid(inValid), .inReady(inReady), .dataIn(dataIn), .en(en),
      .dataOut(dataOut), .closed(closed), .busy(busy), .frameCnt(frameCnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (en === 1'b1) begin
         frames_q.push_back({dataOut[3], dataOut[2], dataOut[1], dataOut[0]});
         en_q.push_back(cyc);
      end
      if (closed === 1'b1 && close_cyc < 0) close_cyc = cyc;
      if (inReady !== 1'b1) nr_cnt++;
   endtask

   task automatic clear_log();
      frames_q.delete();
      en_q.delete();
      close_cyc = -1;
      nr_cnt = 0;
   endtask

   task automatic do_reset();
      arm = 1'b0; stop = 1'b0; inValid = 1'b0; dataIn = '0; numFrames = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_log();
   endtask

   task automatic arm_capture(input logic [15:0] n);
      arm = 1'b1;
      numFrames = n;
      tick();
      arm = 1'b0;
      start = cyc;
   endtask

   task automatic feed(input logic signed [7:0] v);
      dataIn = v;
      inValid = 1'b1;
      tick();
      inValid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      total_cnt++; if (en !== 1'b0) $display("FAIL reset_en got %b want 0", en); else pass_cnt++;
      total_cnt++; if (closed !== 1'b0) $display("FAIL reset_closed got %b want 0", closed); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (frameCnt !== 16'd0) $display("FAIL reset_framecnt got %0d want 0", frameCnt); else pass_cnt++;
      total_cnt++; if (inReady !== 1'b1) $display("FAIL reset_inready got %b want 1", inReady); else pass_cnt++;
      total_cnt++;
      if ({dataOut[3], dataOut[2], dataOut[1], dataOut[0]} !== 32'h0)
         $display("FAIL reset_dataout got %h want 00000000", {dataOut[3], dataOut[2], dataOut[1], dataOut[0]});
      else pass_cnt++;
   endtask

   task automatic test_limit();
      do_reset();
      arm_capture(16'd2);
      for (int v = 0; v < 8; v++) feed(8'(v));
      repeat (4) tick();
      total_cnt++; if (frames_q.size() != 2) $display("FAIL limit_nframes got %0d want 2", frames_q.size()); else pass_cnt++;
      total_cnt++; if (frames_q[0] !== 32'h03020100) $display("FAIL limit_frame0 got %h want 03020100", frames_q[0]); else pass_cnt++;
      total_cnt++; if (frames_q[1] !== 32'h07060504) $display("FAIL limit_frame1 got %h want 07060504", frames_q[1]); else pass_cnt++;
      total_cnt++; if (en_q[0] != start + 4) $display("FAIL limit_en0_cycle got %0d want %0d", en_q[0], start + 4); else pass_cnt++;
      total_cnt++; if (en_q[1] != start + 8) $display("FAIL limit_en1_cycle got %0d want %0d", en_q[1], start + 8); else pass_cnt++;
      total_cnt++; if (close_cyc != start + 9) $display("FAIL limit_close_cycle got %0d want %0d", close_cyc, start + 9); else pass_cnt++;
      total_cnt++; if (frameCnt !== 16'd2) $display("FAIL limit_framecnt got %0d want 2", frameCnt); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL limit_busy got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_toggle();
      do_reset();
      arm_capture(16'd2);
      for (int v = 0; v < 8; v++) begin
         feed(8'(v));
         tick();
      end
      repeat (3) tick();
      total_cnt++; if (frames_q.size() != 2) $display("FAIL toggle_nframes got %0d want 2", frames_q.size()); else pass_cnt++;
      total_cnt++; if (frames_q[0] !== 32'h03020100) $display("FAIL toggle_frame0 got %h want 03020100", frames_q[0]); else pass_cnt++;
      total_cnt++; if (frames_q[1] !== 32'h07060504) $display("FAIL toggle_frame1 got %h want 07060504", frames_q[1]); else pass_cnt++;
      total_cnt++; if (en_q[0] != start + 7) $display("FAIL toggle_en0_cycle got %0d want %0d", en_q[0], start + 7); else pass_cnt++;
      total_cnt++; if (en_q[1] != start + 15) $display("FAIL toggle_en1_cycle got %0d want %0d", en_q[1], start + 15); else pass_cnt++;
      total_cnt++; if (close_cyc != start + 16) $display("FAIL toggle_close_cycle got %0d want %0d", close_cyc, start + 16); else pass_cnt++;
   endtask

   task automatic test_stop_flush();
      do_reset();
      arm_capture(16'd0);
      for (int v = 4; v < 10; v++) feed(8'(v));
      stop = 1'b1;
      tick();
      stop = 1'b0;
      total_cnt++; if (inReady !== 1'b0) $display("FAIL flush_inready got %b want 0", inReady); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL flush_busy got %b want 1", busy); else pass_cnt++;
      repeat (4) tick();
      total_cnt++; if (frames_q.size() != 2) $display("FAIL flush_nframes got %0d want 2", frames_q.size()); else pass_cnt++;
      total_cnt++; if (frames_q[0] !== 32'h07060504) $display("FAIL flush_frame0 got %h want 07060504", frames_q[0]); else pass_cnt++;
      total_cnt++; if (frames_q[1] !== 32'h00000908) $display("FAIL flush_pad_frame got %h want 00000908", frames_q[1]); else pass_cnt++;
      total_cnt++; if (en_q[1] != start + 8) $display("FAIL flush_en_cycle got %0d want %0d", en_q[1], start + 8); else pass_cnt++;
      total_cnt++; if (close_cyc != start + 9) $display("FAIL flush_close_cycle got %0d want %0d", close_cyc, start + 9); else pass_cnt++;
      total_cnt++; if (nr_cnt != 1) $display("FAIL flush_notready_cycles got %0d want 1", nr_cnt); else pass_cnt++;
      total_cnt++; if (frameCnt !== 16'd2) $display("FAIL flush_framecnt got %0d want 2", frameCnt); else pass_cnt++;
   endtask

   task automatic test_stop_same_edge();
      do_reset();
      arm_capture(16'd0);
      feed(8'sd1);
      feed(8'sd2);
      feed(8'sd3);
      stop = 1'b1;
      feed(8'sd4);
      stop = 1'b0;
      repeat (4) tick();
      total_cnt++; if (frames_q.size() != 1) $display("FAIL samestop_nframes got %0d want 1", frames_q.size()); else pass_cnt++;
      total_cnt++; if (frames_q[0] !== 32'h04030201) $display("FAIL samestop_frame got %h want 04030201", frames_q[0]); else pass_cnt++;
      total_cnt++; if (close_cyc != start + 5) $display("FAIL samestop_close_cycle got %0d want %0d", close_cyc, start + 5); else pass_cnt++;
      total_cnt++; if (frameCnt !== 16'd1) $display("FAIL samestop_framecnt got %0d want 1", frameCnt); else pass_cnt++;
   endtask

   task automatic test_idle_discard();
      do_reset();
      feed(-8'sd1);
      feed(-8'sd2);
      arm_capture(16'd1);
      feed(-8'sd128);
      feed(8'sd127);
      feed(8'sd10);
      feed(-8'sd5);
      repeat (3) tick();
      total_cnt++; if (frames_q.size() != 1) $display("FAIL idle_nframes got %0d want 1", frames_q.size()); else pass_cnt++;
      total_cnt++; if (frames_q[0] !== 32'hFB0A7F80) $display("FAIL idle_frame got %h want fb0a7f80", frames_q[0]); else pass_cnt++;
      total_cnt++; if (dataOut[3] !== -8'sd5) $display("FAIL idle_lane3_signed got %0d want -5", dataOut[3]); else pass_cnt++;
      total_cnt++; if (closed !== 1'b1) $display("FAIL idle_closed got %b want 1", closed); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      arm_capture(16'd0);
      for (int v = 1; v < 7; v++) feed(8'(v));
      total_cnt++; if (frameCnt !== 16'd1) $display("FAIL arst_pre_framecnt got %0d want 1", frameCnt); else pass_cnt++;
      #2;
      rst = 1'b1;
      #1;
      total_cnt++; if (en !== 1'b0) $display("FAIL arst_en got %b want 0", en); else pass_cnt++;
      total_cnt++; if (closed !== 1'b0) $display("FAIL arst_closed got %b want 0", closed); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (frameCnt !== 16'd0) $display("FAIL arst_framecnt got %0d want 0", frameCnt); else pass_cnt++;
      total_cnt++;
      if ({dataOut[3], dataOut[2], dataOut[1], dataOut[0]} !== 32'h0)
         $display("FAIL arst_dataout got %h want 00000000", {dataOut[3], dataOut[2], dataOut[1], dataOut[0]});
      else pass_cnt++;
      #1;
      rst = 1'b0;
      clear_log();
      arm_capture(16'd1);
      for (int v = 20; v < 24; v++) feed(8'(v));
      repeat (3) tick();
      total_cnt++; if (frames_q.size() != 1) $display("FAIL arst_rearm_nframes got %0d want 1", frames_q.size()); else pass_cnt++;
      total_cnt++; if (frames_q[0] !== 32'h17161514) $display("FAIL arst_rearm_frame got %h want 17161514", frames_q[0]); else pass_cnt++;
      total_cnt++; if (close_cyc != start + 5) $display("FAIL arst_rearm_close_cycle got %0d want %0d", close_cyc, start + 5); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_limit();
      test_toggle();
      test_stop_flush();
      test_stop_same_edge();
      test_idle_discard();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
